// File: rtl/sobel_pkg.sv
// Shared defaults and constant helpers for the line-buffer / Sobel datapath.
package sobel_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_LINE_WIDTH = 640;
    localparam int DEF_NUM_LINES  = 3;

    // Ceiling log2, never below 1 so that counters always have at least one bit.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) bits++;
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/line_delay.sv
// One image line of delay: a circular buffer read and written at the same address.
module line_delay
    import sobel_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LINE_WIDTH = DEF_LINE_WIDTH
) (
    input  logic                         clk,
    input  logic                         we_i,
    input  logic [clog2(LINE_WIDTH)-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0]        data_i,
    output logic [DATA_WIDTH-1:0]        data_o
);

    logic [DATA_WIDTH-1:0] mem [LINE_WIDTH];

    // Asynchronous read returns the entry written LINE_WIDTH accepts ago,
    // before this edge replaces it.
    assign data_o = mem[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= data_i;
        end
    end

endmodule

// File: rtl/multi_line_buffer.sv
// Cascaded line delays producing a registered vertical column of NUM_LINES pixels.
module multi_line_buffer
    import sobel_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int NUM_LINES  = DEF_NUM_LINES
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sof_i,
    input  logic                            we_i,
    input  logic [DATA_WIDTH-1:0]           data_i,
    output logic [DATA_WIDTH*NUM_LINES-1:0] taps_o,
    output logic                            valid_o,
    output logic [clog2(LINE_WIDTH)-1:0]    col_o,
    output logic                            eol_o
);

    localparam int AW = clog2(LINE_WIDTH);
    localparam int RW = clog2(NUM_LINES);
    localparam logic [AW-1:0] COL_LAST = AW'(LINE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(NUM_LINES - 1);

    logic [AW-1:0] ptr;
    logic [AW-1:0] addr;
    logic [RW-1:0] row;
    logic [RW-1:0] row_cur;
    logic          wrap;
    logic          we_mem;

    logic [DATA_WIDTH-1:0]           dly_in  [NUM_LINES-1];
    logic [DATA_WIDTH-1:0]           dly_out [NUM_LINES-1];
    logic [DATA_WIDTH*NUM_LINES-1:0] taps_next;

    // A start-of-frame pixel is forced to row 0, column 0 regardless of the pointer.
    assign addr    = sof_i ? '0 : ptr;
    assign row_cur = sof_i ? '0 : row;
    assign wrap    = (addr == COL_LAST);
    assign we_mem  = we_i && !rst;

    assign dly_in[0] = data_i;

    for (genvar k = 0; k < NUM_LINES - 1; k++) begin : g_delay
        if (k > 0) begin : g_chain
            assign dly_in[k] = dly_out[k-1];
        end
        line_delay #(
            .DATA_WIDTH(DATA_WIDTH),
            .LINE_WIDTH(LINE_WIDTH)
        ) u_line_delay (
            .clk   (clk),
            .we_i  (we_mem),
            .addr_i(addr),
            .data_i(dly_in[k]),
            .data_o(dly_out[k])
        );
    end

    always_comb begin
        taps_next = '0;
        taps_next[DATA_WIDTH-1:0] = data_i;
        for (int k = 0; k < NUM_LINES - 1; k++) begin
            taps_next[(k+1)*DATA_WIDTH +: DATA_WIDTH] = dly_out[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            row     <= '0;
            taps_o  <= '0;
            col_o   <= '0;
            valid_o <= 1'b0;
            eol_o   <= 1'b0;
        end else if (we_i) begin
            ptr     <= wrap ? '0 : addr + AW'(1);
            row     <= (wrap && row_cur != ROW_LAST) ? row_cur + RW'(1) : row_cur;
            taps_o  <= taps_next;
            col_o   <= addr;
            valid_o <= (row_cur == ROW_LAST);
            eol_o   <= wrap;
        end else begin
            valid_o <= 1'b0;
            eol_o   <= 1'b0;
            if (sof_i) begin
                ptr <= '0;
                row <= '0;
            end
        end
    end

endmodule

// File: doc/multi_line_buffer.md
MULTI_LINE_BUFFER -- requirements
Module: multi_line_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: pixel width in bits.
REQ-002 Parameter LINE_WIDTH, default 640: pixels per image line and depth of each line delay.
REQ-003 Parameter NUM_LINES, default 3: vertical taps produced, which requires NUM_LINES-1 line delays; legal range 2..8.
REQ-004 clk  in  1  clock; all logic is rising-edge.
REQ-005 rst  in  1  reset: synchronous, active-high.
REQ-006 sof_i  in  1  start of frame; qualifies the pixel on data_i when we_i=1.
REQ-007 we_i  in  1  pixel valid; the buffer advances only when high.
REQ-008 data_i  in  DATA_WIDTH  input pixel, raster order.
REQ-009 taps_o  out  DATA_WIDTH*NUM_LINES  vertical column; slice k is the pixel from k lines earlier, so slice 0 is the newest.
REQ-010 valid_o  out  1  taps_o holds a complete column.
REQ-011 col_o  out  clog2(LINE_WIDTH)  column index of the pixel in taps_o.
REQ-012 eol_o  out  1  the pixel in taps_o is the last column of its line.

Function
REQ-013 Each line delay SHALL be a circular buffer of LINE_WIDTH entries with a single pointer: read old entry and write new entry at the same address in one we_i cycle, giving exactly LINE_WIDTH accepted-pixel delay.
REQ-014 Delays SHALL be cascaded: the input of delay 0 is data_i; the input of delay k is the output of delay k-1; slice k+1 of taps_o is the output of delay k.
REQ-015 All delays SHALL share one column pointer, which advances only on we_i and wraps from LINE_WIDTH-1 to 0.
REQ-016 taps_o, valid_o, col_o and eol_o SHALL be registered with 1-cycle latency from the accepting we_i edge.
REQ-017 When we_i=0, pointer, counters, memory and taps_o SHALL hold; valid_o and eol_o SHALL be 0.
REQ-018 A row counter SHALL increment on each wrap, saturating at NUM_LINES-1.
REQ-019 valid_o SHALL be 1 one cycle after an accepted pixel whose row counter equals NUM_LINES-1, and 0 otherwise.
REQ-020 eol_o SHALL be 1 with an output pixel whose col_o equals LINE_WIDTH-1.
REQ-021 sof_i=1 with we_i=1 SHALL treat data_i as row 0, column 0: pointer and row counter restart and the pixel is written at address 0. Memory is not cleared, and valid_o stays 0 until NUM_LINES-1 new lines have been accepted.
REQ-022 sof_i=1 with we_i=0 SHALL zero the pointer and row counter only; the next accepted pixel is column 0.
REQ-023 sof_i asserted mid-line SHALL discard the partial line, with no eol_o for it.
REQ-024 The pointer and counters SHALL be sized clog2(LINE_WIDTH) and clog2(NUM_LINES) bits, with no overflow at non-power-of-two LINE_WIDTH.

Reset
REQ-025 rst SHALL zero the pointer, row counter, taps_o, col_o, valid_o and eol_o; memory contents are left undefined.
REQ-026 rst SHALL take priority over sof_i and we_i in the same cycle.
REQ-027 rst asserted mid-frame SHALL abandon the frame; valid_o stays 0 until NUM_LINES-1 full lines have been refilled.

Structure
REQ-028 The default DATA_WIDTH, LINE_WIDTH and NUM_LINES, and a clog2 constant function, SHALL live in shared package sobel_pkg.
REQ-029 The single line delay SHALL be sub-module line_delay (DATA_WIDTH, LINE_WIDTH; ports clk, we_i, addr_i, data_i, data_o), instantiated NUM_LINES-1 times by a generate loop.
REQ-030 The pointer and counters SHALL exist once, in multi_line_buffer.

Verification (DATA_WIDTH=8, LINE_WIDTH=4, NUM_LINES=3)
REQ-031 Reset, then 12 pixels 1..12 with we_i=1 -> valid_o=0 for pixels 1..8; pixel 9 gives taps_o={1,5,9} (slice2..0), col_o=0; pixel 12 gives {4,8,12}, eol_o=1.
REQ-032 Same stream with we_i=0 on alternate cycles -> identical taps/col sequence, valid_o=0 and eol_o=0 in idle cycles, taps_o held.
REQ-033 After 10 pixels, sof_i=1 with pixel 100 -> col_o=0, valid_o=0 for the next 8 accepted pixels, then taps_o={100,...} pattern restarts.
REQ-034 rst asserted at pixel 6 with we_i=1 -> all outputs 0 next cycle; the next 8 pixels give valid_o=0.
REQ-035 LINE_WIDTH=5 (non-power-of-two), 15 pixels -> pointer wraps 4->0, eol_o on pixels 5, 10 and 15, and first valid column at pixel 11 is {1,6,11}.
REQ-036 NUM_LINES=2 -> first valid_o at pixel 5, taps_o={1,5}.
